// File: rtl/regfile_write_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter and the register file.
// Entry count and widths live here so both sides agree on the file geometry.
package regfile_write_arbiter_pkg;

    localparam int DATA_W_DEF  = 8;
    localparam int ID_W_DEF    = 2;
    localparam int REG_ENTRIES = 2 ** ID_W_DEF;
    localparam int IDX_W       = 3;

    typedef enum logic {
        ST_ARB   = 1'b0,
        ST_SWEEP = 1'b1
    } state_t;

endpackage

// File: rtl/regfile_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid index at or after ptr, wrapping at N-1.
// Returns a one-hot grant plus the binary index of the winner.
module regfile_write_arbiter_rr_pick
    import regfile_write_arbiter_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [N-1:0]     valid,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        int j;
        j     = 0;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = 0; k < N; k++) begin
            // explicit wrap keeps non-power-of-2 requester counts in range
            j = int'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!any && valid[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Write-side controller for the register file: round-robin arbitration of the single
// write port plus a clear sweep; mem_* are registered so they are stable at the file's negedge write.
//
//   state    | meaning
//   ST_ARB   | arbitration active, one accepted write per cycle
//   ST_SWEEP | clear in progress, sc walks every entry writing zero
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ID_W    = ID_W_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ID_W-1:0]   req_id,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic                      clear_req,
    output logic                      clear_busy,
    output logic                      mem_hold,
    output logic [ID_W-1:0]           mem_write_id,
    output logic [DATA_W-1:0]         mem_new_data,
    output logic [2:0]                grant_idx
);

    localparam logic [ID_W-1:0] LAST_ID = ID_W'(2 ** ID_W - 1);

    state_t             state_q;
    state_t             state_d;
    logic [ID_W-1:0]    sc_q;
    logic [IDX_W-1:0]   rr_ptr_q;
    logic [IDX_W-1:0]   pick_idx;
    logic [NUM_REQ-1:0] pick_grant;
    logic               pick_any;
    logic               arb_open;
    logic               fire;
    logic               start_sweep;
    logic               sweep_done;
    logic [ID_W-1:0]    sel_id;
    logic [DATA_W-1:0]  sel_data;

    regfile_write_arbiter_rr_pick #(
        .N (NUM_REQ)
    ) u_rr_pick (
        .valid (req_valid),
        .ptr   (rr_ptr_q),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_ARB;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ARB:   if (clear_req) state_d = ST_SWEEP;
            ST_SWEEP: if (sweep_done) state_d = ST_ARB;
            default:  state_d = ST_ARB;
        endcase
    end

    // clear_req wins over arbitration in the cycle it is seen
    always_comb begin
        arb_open    = (state_q == ST_ARB) && !clear_req;
        start_sweep = (state_q == ST_ARB) && clear_req;
        sweep_done  = (sc_q == LAST_ID);
        req_ready   = arb_open ? pick_grant : '0;
        fire        = arb_open && pick_any;
        sel_id      = req_id[int'(pick_idx)*ID_W +: ID_W];
        sel_data    = req_data[int'(pick_idx)*DATA_W +: DATA_W];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_hold     <= 1'b1;
            mem_write_id <= '0;
            mem_new_data <= '0;
            clear_busy   <= 1'b0;
            grant_idx    <= '0;
            rr_ptr_q     <= '0;
            sc_q         <= '0;
        end else if (start_sweep) begin
            mem_hold     <= 1'b0;
            mem_write_id <= '0;
            mem_new_data <= '0;
            clear_busy   <= 1'b1;
            sc_q         <= '0;
        end else if (state_q == ST_SWEEP) begin
            if (sweep_done) begin
                mem_hold   <= 1'b1;
                clear_busy <= 1'b0;
            end else begin
                sc_q         <= sc_q + 1'b1;
                mem_write_id <= sc_q + 1'b1;
                mem_new_data <= '0;
                mem_hold     <= 1'b0;
            end
        end else if (fire) begin
            mem_hold     <= 1'b0;
            mem_write_id <= sel_id;
            mem_new_data <= sel_data;
            grant_idx    <= pick_idx;
            rr_ptr_q     <= (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
        end else begin
            mem_hold <= 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios plus randomized traffic,
// checked cycle by cycle against a behavioural model with its own register-file image.
module tb_regfile_write_arbiter;

    localparam int N  = 3;
    localparam int IW = 2;
    localparam int DW = 8;
    localparam int NE = 4;

    logic              clk;
    logic              reset;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*IW-1:0]   req_id;
    logic [N*DW-1:0]   req_data;
    logic              clear_req;
    logic              clear_busy;
    logic              mem_hold;
    logic [IW-1:0]     mem_write_id;
    logic [DW-1:0]     mem_new_data;
    logic [2:0]        grant_idx;

    regfile_write_arbiter #(
        .NUM_REQ (N),
        .DATA_W  (DW),
        .ID_W    (IW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_id       (req_id),
        .req_data     (req_data),
        .clear_req    (clear_req),
        .clear_busy   (clear_busy),
        .mem_hold     (mem_hold),
        .mem_write_id (mem_write_id),
        .mem_new_data (mem_new_data),
        .grant_idx    (grant_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // register file fed by the DUT, written at the negedge
    logic [DW-1:0] tfile [NE];
    always @(negedge clk) begin
        if (reset && !mem_hold) tfile[mem_write_id] = mem_new_data;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // stimulus
    logic [N-1:0]  drv_valid;
    logic [IW-1:0] drv_id   [N];
    logic [DW-1:0] drv_data [N];
    logic          drv_clear;

    // reference model
    int            m_ptr;
    int            sweep_q[$];
    logic          e_busy;
    logic          e_hold;
    logic [IW-1:0] e_wid;
    logic [DW-1:0] e_data;
    int            e_gidx;
    logic [DW-1:0] mfile [NE];
    logic [N-1:0]  exp_ready;
    logic [N-1:0]  exp_fire;
    logic          pend_v;
    logic [IW-1:0] pend_id;
    logic [DW-1:0] pend_d;

    task automatic model_reset();
        m_ptr  = 0;
        sweep_q.delete();
        e_busy = 1'b0;
        e_hold = 1'b1;
        e_wid  = '0;
        e_data = '0;
        e_gidx = 0;
        pend_v = 1'b0;
    endtask

    task automatic step();
        bit found;
        int w;
        req_valid = drv_valid;
        for (int i = 0; i < N; i++) begin
            req_id[i*IW +: IW]   = drv_id[i];
            req_data[i*DW +: DW] = drv_data[i];
        end
        clear_req = drv_clear;
        #1;
        exp_ready = '0;
        found     = 1'b0;
        w         = 0;
        if (!e_busy && !drv_clear) begin
            for (int k = 0; k < N; k++) begin
                if (!found && drv_valid[(m_ptr + k) % N]) begin
                    found = 1'b1;
                    w     = (m_ptr + k) % N;
                end
            end
        end
        if (found) exp_ready[w] = 1'b1;
        check_val("req_ready", 32'(req_ready), 32'(exp_ready));
        exp_fire = exp_ready & drv_valid;

        if (!e_busy && drv_clear) begin
            sweep_q = {1, 2, 3};
            e_busy  = 1'b1;
            e_hold  = 1'b0;
            e_wid   = '0;
            e_data  = '0;
        end else if (e_busy) begin
            if (sweep_q.size() > 0) begin
                e_wid  = IW'(sweep_q.pop_front());
                e_data = '0;
                e_hold = 1'b0;
            end else begin
                e_busy = 1'b0;
                e_hold = 1'b1;
            end
        end else if (found) begin
            e_hold = 1'b0;
            e_wid  = drv_id[w];
            e_data = drv_data[w];
            e_gidx = w;
            m_ptr  = (w + 1) % N;
        end else begin
            e_hold = 1'b1;
        end

        @(posedge clk);
        #1;
        if (pend_v) mfile[pend_id] = pend_d;
        pend_v  = !e_hold;
        pend_id = e_wid;
        pend_d  = e_data;
        check_val("mem_hold", 32'(mem_hold), 32'(e_hold));
        check_val("clear_busy", 32'(clear_busy), 32'(e_busy));
        check_val("mem_write_id", 32'(mem_write_id), 32'(e_wid));
        check_val("mem_new_data", 32'(mem_new_data), 32'(e_data));
        if (!e_hold && !e_busy) check_val("grant_idx", 32'(grant_idx), 32'(e_gidx));
        drv_clear = 1'b0;
    endtask

    task automatic idle_inputs();
        drv_valid = '0;
        drv_clear = 1'b0;
        for (int i = 0; i < N; i++) begin
            drv_id[i]   = '0;
            drv_data[i] = '0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_hold"}, 32'(mem_hold), 32'd1);
        check_val({tag, "_busy"}, 32'(clear_busy), 32'd0);
        check_val({tag, "_wid"}, 32'(mem_write_id), 32'd0);
        check_val({tag, "_data"}, 32'(mem_new_data), 32'd0);
        check_val({tag, "_gidx"}, 32'(grant_idx), 32'd0);
    endtask

    initial begin
        int busy_cnt;
        for (int i = 0; i < NE; i++) begin
            tfile[i] = '0;
            mfile[i] = '0;
        end
        idle_inputs();
        req_valid = '0;
        req_id    = '0;
        req_data  = '0;
        clear_req = 1'b0;
        reset     = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #2;
        check_reset_outputs("rst");
        check_val("rst_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #2;
        reset = 1'b1;

        // single request
        drv_valid   = 3'b001;
        drv_id[0]   = 2'd2;
        drv_data[0] = 8'hA5;
        step();
        idle_inputs();
        step();
        check_val("file2_a5", 32'(tfile[2]), 32'h0A5);

        // all three requesters continuously valid
        drv_valid = 3'b111;
        for (int i = 0; i < N; i++) begin
            drv_id[i]   = IW'(i);
            drv_data[i] = DW'(8'h11 * (i + 1));
        end
        repeat (7) step();

        // req1 held while req0 toggles
        drv_valid   = 3'b010;
        drv_id[1]   = 2'd1;
        drv_data[1] = 8'h5C;
        drv_id[0]   = 2'd0;
        drv_data[0] = 8'hC5;
        for (int c = 0; c < 6; c++) begin
            drv_valid[0] = c[0];
            step();
        end

        // load 11/22/33/44, then clear while req0 is valid
        idle_inputs();
        drv_valid = 3'b001;
        for (int e = 0; e < NE; e++) begin
            drv_id[0]   = IW'(e);
            drv_data[0] = DW'(8'h11 * (e + 1));
            step();
        end
        drv_id[0]   = 2'd3;
        drv_data[0] = 8'h77;
        drv_clear   = 1'b1;
        step();
        repeat (6) step();
        idle_inputs();
        step();
        check_val("clr_file0", 32'(tfile[0]), 32'd0);
        check_val("clr_file1", 32'(tfile[1]), 32'd0);
        check_val("clr_file2", 32'(tfile[2]), 32'd0);
        check_val("clr_file3", 32'(tfile[3]), 32'h77);

        // back-to-back and in-sweep clear pulses
        busy_cnt  = 0;
        drv_clear = 1'b1;
        step();
        if (clear_busy) busy_cnt++;
        drv_clear = 1'b1;
        step();
        if (clear_busy) busy_cnt++;
        step();
        if (clear_busy) busy_cnt++;
        step();
        if (clear_busy) busy_cnt++;
        drv_clear = 1'b1;
        step();
        if (clear_busy) busy_cnt++;
        step();
        if (clear_busy) busy_cnt++;
        check_val("sweep_len", 32'(busy_cnt), 32'd4);

        // reset mid-sweep at sc=2
        drv_valid   = 3'b100;
        drv_id[2]   = 2'd2;
        drv_data[2] = 8'h5A;
        step();
        drv_id[2]   = 2'd3;
        drv_data[2] = 8'hC3;
        step();
        idle_inputs();
        step();
        drv_clear = 1'b1;
        step();
        step();
        step();
        #1;
        reset = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("midrst");
        @(posedge clk);
        #2;
        reset = 1'b1;
        #4;
        check_val("keep_file2", 32'(tfile[2]), 32'h5A);
        check_val("keep_file3", 32'(tfile[3]), 32'hC3);
        check_val("swept_file1", 32'(tfile[1]), 32'd0);
        for (int i = 0; i < NE; i++) mfile[i] = tfile[i];
        drv_valid = 3'b111;
        for (int i = 0; i < N; i++) begin
            drv_id[i]   = IW'(i + 1);
            drv_data[i] = DW'(8'h30 + i);
        end
        repeat (4) step();

        // randomized traffic
        idle_inputs();
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                if (exp_fire[i] || !drv_valid[i]) begin
                    drv_valid[i] = ($urandom_range(0, 1) == 1);
                    drv_id[i]    = IW'($urandom_range(0, NE - 1));
                    drv_data[i]  = DW'($urandom_range(0, 255));
                end else if ($urandom_range(0, 7) == 0) begin
                    drv_valid[i] = 1'b0;
                end
            end
            drv_clear = ($urandom_range(0, 15) == 0);
            step();
        end
        idle_inputs();
        step();
        @(negedge clk);
        #1;
        if (pend_v) mfile[pend_id] = pend_d;
        pend_v = 1'b0;
        for (int i = 0; i < NE; i++) begin
            check_val($sformatf("final_file%0d", i), 32'(tfile[i]), 32'(mfile[i]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Write-side controller for the 4 x 8-bit register file.
- Shares the file's single write port between NUM_REQ requesters using round-robin arbitration with a valid/ready handshake.
- Also sequences a 4-cycle clear sweep that zeroes all entries.
- Drives the file's hold / write_id / new_data inputs from posedge registers, so those inputs are stable at the file's negedge write.

Parameters:
NUM_REQ, 3, number of write requesters (2..8)
DATA_W, 8, data width of one register entry
ID_W, 2, register index width (2**ID_W entries, swept by clear)

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  asynchronous, active-low reset
req_valid  input  NUM_REQ  per-requester write request
req_ready  output  NUM_REQ  per-requester accept, combinational, one-hot or zero
req_id  input  NUM_REQ*ID_W  packed target index; requester i at [i*ID_W +: ID_W]
req_data  input  NUM_REQ*DATA_W  packed write data; requester i at [i*DATA_W +: DATA_W]
clear_req  input  1  single-cycle pulse that starts a clear sweep
clear_busy  output  1  high while the sweep is in progress
mem_hold  output  1  to register file hold; 1 = no write this cycle
mem_write_id  output  ID_W  to register file write_id
mem_new_data  output  DATA_W  to register file new_data
grant_idx  output  3  index of the requester whose write is on mem_* this cycle; valid when mem_hold=0 and clear_busy=0

Behaviour:
- Reset values (reset low, async): mem_hold=1, mem_write_id=0, mem_new_data=0, clear_busy=0, grant_idx=0, rr_ptr=0, state=IDLE. Assertion mid-sweep or mid-write aborts immediately; no pending state survives.
- States:
  - IDLE/ARB: arbitration active.
  - SWEEP: clear in progress; 2-bit sweep counter sc.
- Arbitration (ARB only):
  - Scan req_valid starting at rr_ptr, increasing index, wrapping at NUM_REQ-1 -> 0.
  - The first valid requester w gets req_ready[w]=1; all other bits are 0.
  - Handshake fires when req_valid[w] && req_ready[w].
  - On fire, next posedge: mem_hold=0, mem_write_id=req_id[w], mem_new_data=req_data[w], grant_idx=w, rr_ptr=(w+1) mod NUM_REQ.
  - With no fire: mem_hold=1; mem_write_id and mem_new_data hold their previous values; rr_ptr unchanged.
  - Latency: accept at edge N, write visible on mem_* from N to N+1, committed by the file at the following negedge.
  - Throughput: 1 write per cycle, back-to-back.
- Requesters must hold valid, id and data stable until accepted. A requester may drop valid without penalty.
- Clear:
  - clear_req=1 in ARB takes priority over arbitration that cycle: req_ready=0, no fire.
  - Next edge: state=SWEEP, clear_busy=1, sc=0, mem_hold=0, mem_write_id=0, mem_new_data=0.
  - Each subsequent edge: sc++, mem_write_id=sc+1, data 0.
  - After the write to entry 3 (2**ID_W-1), next edge: state=ARB, clear_busy=0, mem_hold=1.
  - Sweep is 4 write cycles; clear_busy is high for exactly 4 cycles.
  - A write accepted the cycle before clear_req is already on mem_* and completes normally; the sweep then follows it.
- During SWEEP: req_ready=0 and clear_req is ignored (not queued).
- rr_ptr is unchanged by a sweep.
- Simultaneous same-id requests are impossible (one grant per cycle). Consecutive grants to the same id write in grant order.
- Out-of-range rr_ptr cannot occur. Wrap is explicit for non-power-of-2 NUM_REQ.

Decomposition:
- Shared package holds:
  - state encoding (ST_ARB, ST_SWEEP)
  - REG_ENTRIES = 2**ID_W
  - DATA_W / ID_W defaults, shared with the register file
- One natural sub-module: rr_pick. It is purely combinational: takes valid vector and pointer, returns one-hot grant and binary winner index. Reusable by other arbiters in the design.

Test Plan:
- Reset, then a single request: req_valid=3'b001, req_id0=2, req_data0=8'hA5 -> ready0=1 that cycle; next cycle mem_hold=0, mem_write_id=2, mem_new_data=A5, grant_idx=0; file entry 2 reads A5.
- All three valid continuously, distinct ids 0/1/2, data 11/22/33 -> grants in order 0,1,2,0,...; mem_hold never 1; each requester served once per 3 cycles.
- Round-robin fairness: req1 held valid while req0 toggles every cycle -> req1 granted within 2 cycles; rr_ptr advances past each winner.
- Clear after load: entries = 11/22/33/44, pulse clear_req while req0 valid -> ready0=0 that cycle; clear_busy high 4 cycles with write_id 0,1,2,3 and data 0; all entries 0; req0 granted the cycle after clear_busy falls.
- clear_req during SWEEP and back-to-back clear_req pulses -> second pulse ignored; sweep still exactly 4 cycles.
- reset asserted low at sc=2 -> outputs at reset values immediately (mem_hold=1, clear_busy=0); entries 2 and 3 not zeroed by the arbiter; after release, normal arbitration resumes from rr_ptr=0.
